// File: rtl/gshare_predictor_pkg.sv
// Shared defaults for the branch direction predictor slice.
// Holds the core address width and the predictor table/history sizing.
// Pure constants: no logic, no latency, no flow control.
package gshare_predictor_pkg;

    // Core address/statistic width shared with the rest of the fetch path.
    localparam int CORE_XLEN    = 32;

    // Predictor sizing defaults: PHT index bits, global history length, counter width.
    localparam int BP_PHT_WIDTH = 8;
    localparam int BP_HIST_LEN  = 8;
    localparam int BP_CTR_BITS  = 2;

endpackage

// File: rtl/gshare_predictor_bp_history_reg.sv
// Speculative and architectural global branch history registers.
// Latency: updates visible the cycle after the sampling edge.
// No backpressure: shifts whenever enabled; flush restores spec from arch (incl. same-cycle commit).
module bp_history_reg
    import gshare_predictor_pkg::*;
#(
    parameter int HIST_LEN = BP_HIST_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                spec_shift_vld,
    input  logic                spec_shift_bit,
    input  logic                commit_vld,
    input  logic                commit_bit,
    output logic [HIST_LEN-1:0] spec_ghr,
    output logic [HIST_LEN-1:0] arch_ghr
);

    logic [HIST_LEN-1:0] spec_ghr_q, spec_ghr_d;
    logic [HIST_LEN-1:0] arch_ghr_q, arch_ghr_d;

    // Oldest outcome drops off the MSB, newest enters at the LSB; works for HIST_LEN == 1 too.
    function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] h,
                                                     input logic                b);
        return HIST_LEN'({h, b});
    endfunction

    // Next-state: commit advances arch; flush copies the post-commit arch into spec and wins over a fetch shift.
    always_comb begin
        arch_ghr_d = arch_ghr_q;
        spec_ghr_d = spec_ghr_q;
        if (commit_vld) begin
            arch_ghr_d = shift_in(arch_ghr_q, commit_bit);
        end
        if (flush) begin
            spec_ghr_d = arch_ghr_d;
        end else if (spec_shift_vld) begin
            spec_ghr_d = shift_in(spec_ghr_q, spec_shift_bit);
        end
    end

    // State register: everything frozen while rdy is low, reset included.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                spec_ghr_q <= '0;
                arch_ghr_q <= '0;
            end else begin
                spec_ghr_q <= spec_ghr_d;
                arch_ghr_q <= arch_ghr_d;
            end
        end
    end

    assign spec_ghr = spec_ghr_q;
    assign arch_ghr = arch_ghr_q;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor with speculative history and commit-time training.
// Latency: lookup is combinational (0 cycles); training/history/statistics land one cycle after the edge.
// No backpressure: every lookup and commit is accepted; rdy low freezes all state.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int       XLEN       = CORE_XLEN,
    parameter int       PHT_WIDTH  = BP_PHT_WIDTH,
    parameter int       HIST_LEN   = BP_HIST_LEN,
    parameter int       CTR_BITS   = BP_CTR_BITS,
    parameter bit       USE_GSHARE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic [XLEN-1:0]     fet_pc,
    input  logic                fet_br_valid,
    output logic                bp_pred,
    output logic [HIST_LEN-1:0] bp_ghr,
    input  logic                rob_bp_enable,
    input  logic [XLEN-1:0]     rob_bp_inst_addr,
    input  logic [HIST_LEN-1:0] rob_bp_ghr,
    input  logic                rob_bp_jump,
    input  logic                rob_bp_correct,
    output logic [XLEN-1:0]     bp_correct_cnt,
    output logic [XLEN-1:0]     bp_total_cnt
);

    localparam int                 PHT_DEPTH = 1 << PHT_WIDTH;
    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0]  pht_q [PHT_DEPTH];
    logic [CTR_BITS-1:0]  pht_d [PHT_DEPTH];
    logic [XLEN-1:0]      correct_cnt_q, correct_cnt_d;
    logic [XLEN-1:0]      total_cnt_q, total_cnt_d;
    logic [HIST_LEN-1:0]  spec_ghr;
    logic [HIST_LEN-1:0]  arch_ghr;
    logic [PHT_WIDTH-1:0] fet_idx;
    logic [PHT_WIDTH-1:0] upd_idx;
    logic                 unused_pc_bits;

    // Saturating up/down counter step.
    function automatic logic [CTR_BITS-1:0] sat_update(input logic [CTR_BITS-1:0] ctr,
                                                       input logic                taken);
        logic [CTR_BITS-1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) nxt = ctr + 1'b1;
        end else begin
            if (ctr != '0) nxt = ctr - 1'b1;
        end
        return nxt;
    endfunction

    // PC is halfword aligned, so bit 0 is skipped; history is zero-extended into the LSBs.
    function automatic logic [PHT_WIDTH-1:0] pht_idx(input logic [PHT_WIDTH-1:0] pc_bits,
                                                     input logic [HIST_LEN-1:0]  h);
        logic [PHT_WIDTH-1:0] hx;
        hx = USE_GSHARE ? PHT_WIDTH'(h) : '0;
        return pc_bits ^ hx;
    endfunction

    // PC bits outside the index window carry no information for this table.
    assign unused_pc_bits = ^{fet_pc[XLEN-1:PHT_WIDTH+1], fet_pc[0],
                              rob_bp_inst_addr[XLEN-1:PHT_WIDTH+1], rob_bp_inst_addr[0]};

    assign fet_idx = pht_idx(fet_pc[PHT_WIDTH:1], spec_ghr);
    assign upd_idx = pht_idx(rob_bp_inst_addr[PHT_WIDTH:1], rob_bp_ghr);

    // Lookup reads the registered table, so a same-cycle update to this entry is not seen.
    assign bp_pred = pht_q[fet_idx][CTR_BITS-1];
    assign bp_ghr  = spec_ghr;

    bp_history_reg #(
        .HIST_LEN (HIST_LEN)
    ) u_hist (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .spec_shift_vld (fet_br_valid),
        .spec_shift_bit (bp_pred),
        .commit_vld     (rob_bp_enable),
        .commit_bit     (rob_bp_jump),
        .spec_ghr       (spec_ghr),
        .arch_ghr       (arch_ghr)
    );

    // Training and statistics on commit; flush does not block training.
    always_comb begin
        pht_d         = pht_q;
        correct_cnt_d = correct_cnt_q;
        total_cnt_d   = total_cnt_q;
        if (rob_bp_enable) begin
            pht_d[upd_idx] = sat_update(pht_q[upd_idx], rob_bp_jump);
            total_cnt_d    = total_cnt_q + 1'b1;
            correct_cnt_d  = correct_cnt_q + XLEN'(rob_bp_correct);
        end
    end

    // Table and statistic registers: synchronous reset, all state held while rdy is low.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                for (int i = 0; i < PHT_DEPTH; i++) begin
                    pht_q[i] <= CTR_INIT;
                end
                correct_cnt_q <= '0;
                total_cnt_q   <= '0;
            end else begin
                pht_q         <= pht_d;
                correct_cnt_q <= correct_cnt_d;
                total_cnt_q   <= total_cnt_d;
            end
        end
    end

    assign bp_correct_cnt = correct_cnt_q;
    assign bp_total_cnt   = total_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a gshare and a bimodal instance share stimulus.
// Directed test-plan scenarios followed by randomized traffic against an integer reference model.
module tb_gshare_predictor;

    localparam int XLEN  = 32;
    localparam int PW    = 8;
    localparam int HL    = 8;
    localparam int CB    = 2;
    localparam int DEPTH = 1 << PW;
    localparam int HMOD  = 1 << HL;
    localparam int CMAX  = (1 << CB) - 1;
    localparam int CINIT = (1 << (CB - 1)) - 1;
    localparam int CHALF = 1 << (CB - 1);

    logic            clk = 1'b0;
    logic            rst, rdy, flush, fet_br_valid;
    logic [XLEN-1:0] fet_pc, rob_bp_inst_addr;
    logic            rob_bp_enable, rob_bp_jump, rob_bp_correct;
    logic [HL-1:0]   rob_bp_ghr;

    logic            pred_g, pred_b;
    logic [HL-1:0]   ghr_g, ghr_b;
    logic [XLEN-1:0] cc_g, tc_g, cc_b, tc_b;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    gshare_predictor #(.XLEN(XLEN), .PHT_WIDTH(PW), .HIST_LEN(HL), .CTR_BITS(CB), .USE_GSHARE(1'b1)) dut_g (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .fet_pc(fet_pc), .fet_br_valid(fet_br_valid),
        .bp_pred(pred_g), .bp_ghr(ghr_g),
        .rob_bp_enable(rob_bp_enable), .rob_bp_inst_addr(rob_bp_inst_addr),
        .rob_bp_ghr(rob_bp_ghr), .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct),
        .bp_correct_cnt(cc_g), .bp_total_cnt(tc_g)
    );

    gshare_predictor #(.XLEN(XLEN), .PHT_WIDTH(PW), .HIST_LEN(HL), .CTR_BITS(CB), .USE_GSHARE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .fet_pc(fet_pc), .fet_br_valid(fet_br_valid),
        .bp_pred(pred_b), .bp_ghr(ghr_b),
        .rob_bp_enable(rob_bp_enable), .rob_bp_inst_addr(rob_bp_inst_addr),
        .rob_bp_ghr(rob_bp_ghr), .rob_bp_jump(rob_bp_jump), .rob_bp_correct(rob_bp_correct),
        .bp_correct_cnt(cc_b), .bp_total_cnt(tc_b)
    );

    // Reference model: index 0 = bimodal instance, 1 = gshare instance.
    int          m_pht [2][DEPTH];
    int          m_spec [2];
    int          m_arch [2];
    int unsigned m_cc, m_tc;

    function automatic int midx(int mode, logic [XLEN-1:0] pc, int h);
        int r;
        r = int'((pc >> 1) & (DEPTH - 1));
        if (mode == 1) r = r ^ h;
        return r;
    endfunction

    function automatic int mpred(int mode);
        return (m_pht[mode][midx(mode, fet_pc, m_spec[mode])] >= CHALF) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < DEPTH; i++) m_pht[m][i] = CINIT;
            m_spec[m] = 0;
            m_arch[m] = 0;
        end
        m_cc = 0;
        m_tc = 0;
    endtask

    task automatic model_step();
        int p [2];
        int anext, u;
        if (!rdy) return;
        if (rst) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) p[m] = mpred(m);
        for (int m = 0; m < 2; m++) begin
            anext = m_arch[m];
            if (rob_bp_enable) begin
                u = midx(m, rob_bp_inst_addr, int'(rob_bp_ghr));
                if (rob_bp_jump) m_pht[m][u] = (m_pht[m][u] < CMAX) ? m_pht[m][u] + 1 : CMAX;
                else             m_pht[m][u] = (m_pht[m][u] > 0)    ? m_pht[m][u] - 1 : 0;
                anext = ((m_arch[m] * 2) + int'(rob_bp_jump)) % HMOD;
            end
            if (flush)             m_spec[m] = anext;
            else if (fet_br_valid) m_spec[m] = ((m_spec[m] * 2) + p[m]) % HMOD;
            m_arch[m] = anext;
        end
        if (rob_bp_enable) begin
            m_tc = m_tc + 1;
            m_cc = m_cc + int'(rob_bp_correct);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("pred_g", 64'(pred_g), 64'(mpred(1)));
        check("pred_b", 64'(pred_b), 64'(mpred(0)));
        check("ghr_g",  64'(ghr_g),  64'(m_spec[1]));
        check("ghr_b",  64'(ghr_b),  64'(m_spec[0]));
        check("cc_g",   64'(cc_g),   64'(m_cc));
        check("tc_g",   64'(tc_g),   64'(m_tc));
        check("cc_b",   64'(cc_b),   64'(m_cc));
        check("tc_b",   64'(tc_b),   64'(m_tc));
    endtask

    // Called at negedge with inputs already driven; ends at the following negedge.
    task automatic tick();
        #1;
        if (chk_en) compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; fet_br_valid = 1'b0;
        fet_pc = '0; rob_bp_enable = 1'b0; rob_bp_inst_addr = '0;
        rob_bp_ghr = '0; rob_bp_jump = 1'b0; rob_bp_correct = 1'b0;
    endtask

    task automatic commit(input logic [XLEN-1:0] pc, input logic [HL-1:0] h, input logic jmp);
        rob_bp_enable = 1'b1; rob_bp_inst_addr = pc; rob_bp_ghr = h;
        rob_bp_jump = jmp; rob_bp_correct = jmp;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [6:0]  sat_dir  = 7'b1110000;
    logic [6:0]  sat_pred = 7'b1111000;
    logic [XLEN-1:0] fet_seq [3] = '{32'h80, 32'h200, 32'h100};
    logic [2:0]  fet_exp  = 3'b101;

    initial begin
        idle();
        model_reset();
        @(negedge clk);

        // Reset state
        do_reset();
        chk_en = 1'b1;
        #1;
        check("rst_pred",  64'(pred_g), 64'd0);
        check("rst_ghr",   64'(ghr_g),  64'd0);
        check("rst_tc",    64'(tc_g),   64'd0);
        check("rst_cc",    64'(cc_g),   64'd0);
        fet_pc = 32'h100;
        #1 check("rst_lookup", 64'(pred_g), 64'd0);
        tick();

        // Saturation on the bimodal instance at PC 0x40: T,T,T then N x4
        for (int i = 0; i < 7; i++) begin
            fet_pc = 32'h40;
            commit(32'h40, '0, sat_dir[6-i]);
            tick();
            rob_bp_enable = 1'b0;
            #1 check($sformatf("sat_pred%0d", i), 64'(pred_b), 64'(sat_pred[6-i]));
        end
        check("sat_total", 64'(tc_b), 64'd7);

        // Reset mid-operation discards training
        do_reset();
        fet_pc = 32'h40;
        #1;
        check("rst2_tc",   64'(tc_b),   64'd0);
        check("rst2_pred", 64'(pred_b), 64'd0);

        // Pre-train entries 0x40, 0x82, 0x25 of the gshare table
        commit(32'h80, 8'h00, 1'b1);  tick();
        commit(32'h100, 8'h02, 1'b1); tick();
        commit(32'h40, 8'h05, 1'b1);  tick();
        idle();
        fet_pc = 32'h40;
        #1 check("pre_idx20", 64'(pred_g), 64'd0);

        // History shift with predictions 1,0,1
        for (int i = 0; i < 3; i++) begin
            fet_pc = fet_seq[i];
            fet_br_valid = 1'b1;
            #1 check($sformatf("shift_pred%0d", i), 64'(pred_g), 64'(fet_exp[2-i]));
            tick();
        end
        idle();
        #1 check("shift_ghr", 64'(ghr_g), 64'h05);
        fet_pc = 32'h40;
        #1 check("idx25_pred", 64'(pred_g), 64'd1);
        tick();

        // Flush with a same-cycle not-taken commit; arch was 0b111
        commit(32'h400, 8'h00, 1'b0);
        flush = 1'b1;
        fet_br_valid = 1'b1;
        fet_pc = 32'h80;
        tick();
        idle();
        #1;
        check("flush_ghr_g", 64'(ghr_g), 64'h0E);
        check("flush_ghr_b", 64'(ghr_b), 64'h0E);

        // Same-cycle lookup and training on entry 0x8E
        fet_pc = 32'h300;
        commit(32'h300, 8'h0E, 1'b1);
        #1 check("coll_pre", 64'(pred_g), 64'd0);
        tick();
        idle();
        fet_pc = 32'h300;
        #1 check("coll_post", 64'(pred_g), 64'd1);

        // rdy low freezes everything, reset included
        for (int i = 0; i < 5; i++) begin
            rdy = 1'b0; rst = 1'b1; fet_br_valid = 1'b1; flush = 1'b1;
            commit(32'h300, 8'h0E, 1'b0);
            fet_pc = 32'h300;
            tick();
        end
        idle();
        fet_pc = 32'h300;
        #1;
        check("rdy_tc",   64'(tc_g),   64'd5);
        check("rdy_ghr",  64'(ghr_g),  64'h0E);
        check("rdy_pred", 64'(pred_g), 64'd1);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy           = ($urandom_range(0, 9) != 0);
            rst           = ($urandom_range(0, 299) == 0);
            flush         = ($urandom_range(0, 19) == 0);
            fet_br_valid  = 1'($urandom);
            fet_pc        = ($urandom & 32'hFFFF_FC01) | (32'($urandom_range(0, 31)) << 1);
            rob_bp_enable = 1'($urandom);
            rob_bp_inst_addr = ($urandom & 32'hFFFF_FC01) | (32'($urandom_range(0, 31)) << 1);
            rob_bp_ghr    = HL'($urandom);
            rob_bp_jump   = 1'($urandom);
            rob_bp_correct = 1'($urandom);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
